decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have one parameter: NOP_INSTR, default 32'h00000013, the instruction word held after reset or flush (addi x0,x0,0).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 Upstream ports SHALL be: instr_f input 32, fetched instruction; pc_f input 32, its PC; pcplus4_f input 32, its PC+4; valid_f input 1, fetch slot holds a real instruction.
REQ-004 Hazard ports SHALL be: stall_d input 1, hold the ID register; flush_d input 1, replace the ID register with a bubble.
REQ-005 Datapath outputs SHALL be: instr_d output 32, feeds the immediate extender; pc_d output 32; pcplus4_d output 32; valid_d output 1; rs1_d, rs2_d, rd_d output 5 each, instr_d[19:15], [24:20], [11:7].
REQ-006 Control outputs SHALL be: immsrc_d output 3; regwrite_d, memwrite_d, branch_d, jump_d, alusrc_d output 1 each; resultsrc_d output 2 (00 ALU, 01 memory, 10 PC+4); aluop_d output 2 (00 add, 01 sub/compare, 10 funct-decoded); illegal_d output 1.

Function
REQ-007 The ID register SHALL hold instr, pc, pcplus4 and valid, updated on each rising clk edge.
REQ-008 When flush_d=1 the register SHALL load instr=NOP_INSTR, pc=0, pcplus4=0, valid=0, regardless of stall_d.
REQ-009 When flush_d=0 and stall_d=1 the register SHALL keep its contents.
REQ-010 When flush_d=0 and stall_d=0 the register SHALL load instr_f, pc_f, pcplus4_f, valid_f; latency from F inputs to D outputs is exactly one cycle.
REQ-011 Control outputs SHALL decode combinationally from the registered instr_d[6:0] only.
REQ-012 immsrc_d SHALL be 000 for I-type and loads and jalr, 001 for S, 010 for B, 011 for J, 100 for U, matching the extender encoding.
REQ-013 The opcode table SHALL be as follows.
- 0000011 load: regwrite, alusrc, resultsrc 01, aluop 00.
- 0100011 store: memwrite, alusrc, aluop 00.
- 0110011 R: regwrite, aluop 10.
- 0010011 I-ALU: regwrite, alusrc, aluop 10.
- 1100011 branch: branch, aluop 01.
- 1101111 jal: regwrite, jump, resultsrc 10.
- 1100111 jalr: regwrite, jump, alusrc, resultsrc 10, aluop 00.
- 0110111 lui and 0010111 auipc: regwrite, alusrc, aluop 00.
REQ-014 Any other opcode with valid_d=1 SHALL assert illegal_d and drive all control outputs to 0, with immsrc_d=000.
REQ-015 When valid_d=0 all control outputs and illegal_d SHALL be 0, and immsrc_d SHALL be 000.
REQ-016 regwrite_d SHALL be forced to 0 when rd_d=0.
REQ-017 stall_d held for N cycles SHALL present identical outputs for those N cycles, with no duplicated or lost instruction.

Reset
REQ-018 While rst=1, asynchronously and independently of clk, the register SHALL be instr=NOP_INSTR, pc=0, pcplus4=0, valid=0; hence every control output is 0 and immsrc_d=000.
REQ-019 Reset deassertion mid-stall SHALL resume with the bubble contents; the first non-stalled edge loads the F inputs.

Structure
REQ-020 The opcode constants, the immsrc encodings (IMM_I..IMM_U), and the resultsrc and aluop encodings SHALL live in the shared core package used by the extender and ALU decoder.
REQ-021 The combinational control table SHALL be one sub-module, main_decoder; the ID register stays in decode_unit.

Verification
REQ-022 Apply rst, then release it with no valid fetch: instr_d=32'h00000013, valid_d=0, all controls 0.
REQ-023 Present instr_f=32'h00A28293 (addi x5,x5,10) with valid_f=1: next cycle rd_d=5, regwrite_d=1, alusrc_d=1, immsrc_d=000, aluop_d=10.
REQ-024 Present sw 32'h0062A223, then beq 32'hFE628EE3, then jal 32'h008000EF: memwrite/immsrc 001, branch/aluop 01/immsrc 010, then jump/resultsrc 10/immsrc 011/rd_d=1 on consecutive cycles.
REQ-025 Load lw, hold stall_d=1 for 3 cycles while changing instr_f, then assert stall_d=1 and flush_d=1 together: outputs are frozen for 3 cycles, then become a bubble (valid_d=0).
REQ-026 Present opcode 1111111 with valid_f=1, and separately addi to rd=0: the first gives illegal_d=1 with controls 0; the second gives regwrite_d=0.
REQ-027 Assert rst asynchronously mid-cycle with a valid R-type held: outputs go to the bubble before the next clk edge.

Source files
------------

// File: rtl/decode_unit_pkg.sv
// Shared core package: opcode constants, immediate-source, result-source and
// ALU-op encodings, plus the control bundle and ID register layout used by
// the decode stage, immediate extender and ALU decoder.
package decode_unit_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Must match the immediate extender's select encoding.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    imm_src_e immsrc;
    logic     regwrite;
    logic     memwrite;
    logic     branch;
    logic     jump;
    logic     alusrc;
    res_src_e resultsrc;
    alu_op_e  aluop;
    logic     illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    immsrc:    IMM_I,
    regwrite:  1'b0,
    memwrite:  1'b0,
    branch:    1'b0,
    jump:      1'b0,
    alusrc:    1'b0,
    resultsrc: RES_ALU,
    aluop:     ALU_ADD,
    illegal:   1'b0
  };

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } id_reg_t;

  // Bubble contents loaded on reset and flush.
  function automatic id_reg_t bubble(input logic [31:0] nop);
    id_reg_t b;
    b.instr   = nop;
    b.pc      = 32'h0;
    b.pcplus4 = 32'h0;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/decode_unit_main_decoder.sv
// main_decoder: combinational control table driven by the opcode of the
// instruction sitting in the ID register.
//   opcode  in  instr_d[6:0]
//   valid   in  ID slot holds a real instruction
//   rd      in  destination register, regwrite is squashed for x0
//   ctrl    out decoded control bundle
module main_decoder
  import decode_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       valid,
  input  logic [4:0] rd,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    if (valid) begin
      case (opcode)
        OP_LOAD: begin
          ctrl.regwrite  = 1'b1;
          ctrl.alusrc    = 1'b1;
          ctrl.resultsrc = RES_MEM;
        end
        OP_STORE: begin
          ctrl.immsrc   = IMM_S;
          ctrl.memwrite = 1'b1;
          ctrl.alusrc   = 1'b1;
        end
        OP_R: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALU_FUNCT;
        end
        OP_I: begin
          ctrl.regwrite = 1'b1;
          ctrl.alusrc   = 1'b1;
          ctrl.aluop    = ALU_FUNCT;
        end
        OP_BRANCH: begin
          ctrl.immsrc = IMM_B;
          ctrl.branch = 1'b1;
          ctrl.aluop  = ALU_SUB;
        end
        OP_JAL: begin
          ctrl.immsrc    = IMM_J;
          ctrl.regwrite  = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.resultsrc = RES_PC4;
        end
        OP_JALR: begin
          ctrl.regwrite  = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.alusrc    = 1'b1;
          ctrl.resultsrc = RES_PC4;
        end
        OP_LUI, OP_AUIPC: begin
          ctrl.immsrc   = IMM_U;
          ctrl.regwrite = 1'b1;
          ctrl.alusrc   = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded; drop them here so the
      // hazard unit never sees a false producer.
      if (rd == 5'd0) ctrl.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/decode_unit.sv
// decode_unit: IF/ID pipeline register plus main control decode.
//   clk, rst                      clock, async active-high reset
//   instr_f, pc_f, pcplus4_f,
//   valid_f                       fetch-stage slot
//   stall_d, flush_d              hazard controls (flush wins over stall)
//   instr_d, pc_d, pcplus4_d,
//   valid_d, rs1_d, rs2_d, rd_d   registered datapath fields
//   immsrc_d .. illegal_d         control decoded from instr_d[6:0]
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic [31:0] pcplus4_f,
  input  logic        valid_f,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [4:0]  rd_d,
  output logic [2:0]  immsrc_d,
  output logic        regwrite_d,
  output logic        memwrite_d,
  output logic        branch_d,
  output logic        jump_d,
  output logic        alusrc_d,
  output logic [1:0]  resultsrc_d,
  output logic [1:0]  aluop_d,
  output logic        illegal_d
);

  id_reg_t id_q;
  id_reg_t id_f;
  ctrl_t   ctrl;

  assign id_f = '{instr: instr_f, pc: pc_f, pcplus4: pcplus4_f, valid: valid_f};

  // Flush takes priority so a redirect can kill a stalled instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           id_q <= bubble(NOP_INSTR);
    else if (flush_d)  id_q <= bubble(NOP_INSTR);
    else if (!stall_d) id_q <= id_f;
  end

  assign instr_d   = id_q.instr;
  assign pc_d      = id_q.pc;
  assign pcplus4_d = id_q.pcplus4;
  assign valid_d   = id_q.valid;
  assign rs1_d     = id_q.instr[19:15];
  assign rs2_d     = id_q.instr[24:20];
  assign rd_d      = id_q.instr[11:7];

  main_decoder u_main_decoder (
    .opcode (id_q.instr[6:0]),
    .valid  (id_q.valid),
    .rd     (id_q.instr[11:7]),
    .ctrl   (ctrl)
  );

  assign immsrc_d    = ctrl.immsrc;
  assign regwrite_d  = ctrl.regwrite;
  assign memwrite_d  = ctrl.memwrite;
  assign branch_d    = ctrl.branch;
  assign jump_d      = ctrl.jump;
  assign alusrc_d    = ctrl.alusrc;
  assign resultsrc_d = ctrl.resultsrc;
  assign aluop_d     = ctrl.aluop;
  assign illegal_d   = ctrl.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed scenarios plus randomized
// traffic, checked against a table-driven reference model.
module tb_decode_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_f = NOP, pc_f = '0, pcplus4_f = '0;
  logic        valid_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  immsrc_d;
  logic        regwrite_d, memwrite_d, branch_d, jump_d, alusrc_d, illegal_d;
  logic [1:0]  resultsrc_d, aluop_d;

  int vectors = 0;
  int miscompares = 0;

  decode_unit #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f), .valid_f(valid_f),
    .stall_d(stall_d), .flush_d(flush_d),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .immsrc_d(immsrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .branch_d(branch_d), .jump_d(jump_d), .alusrc_d(alusrc_d),
    .resultsrc_d(resultsrc_d), .aluop_d(aluop_d), .illegal_d(illegal_d)
  );

  always #5 clk = ~clk;

  // Observed control word: {immsrc, rw, mw, br, jp, as, resultsrc, aluop, illegal}
  wire [12:0]  obs_ctl = {immsrc_d, regwrite_d, memwrite_d, branch_d, jump_d,
                          alusrc_d, resultsrc_d, aluop_d, illegal_d};
  wire [124:0] obs = {instr_d, pc_d, pcplus4_d, valid_d, rs1_d, rs2_d, rd_d, obs_ctl};

  // Reference model state: what the ID slot should hold.
  logic [31:0] m_instr = NOP, m_pc = '0, m_pc4 = '0;
  logic        m_valid = 1'b0;

  // Opcode table {opcode, control word}; a miss means illegal.
  localparam logic [19:0] TBL [9] = '{
    {7'b0000011, 13'b000_1_0_0_0_1_01_00_0},  // load
    {7'b0100011, 13'b001_0_1_0_0_1_00_00_0},  // store
    {7'b0110011, 13'b000_1_0_0_0_0_00_10_0},  // R
    {7'b0010011, 13'b000_1_0_0_0_1_00_10_0},  // I-ALU
    {7'b1100011, 13'b010_0_0_1_0_0_00_01_0},  // branch
    {7'b1101111, 13'b011_1_0_0_1_0_10_00_0},  // jal
    {7'b1100111, 13'b000_1_0_0_1_1_10_00_0},  // jalr
    {7'b0110111, 13'b100_1_0_0_0_1_00_00_0},  // lui
    {7'b0010111, 13'b100_1_0_0_0_1_00_00_0}   // auipc
  };

  function automatic logic [12:0] ref_ctl(input logic [31:0] ins, input logic v);
    logic [12:0] c;
    logic hit;
    c = 13'b0;
    hit = 1'b0;
    if (!v) return 13'b0;
    for (int i = 0; i < 9; i++)
      if (TBL[i][19:13] == ins[6:0]) begin c = TBL[i][12:0]; hit = 1'b1; end
    if (!hit) return 13'b000_0_0_0_0_0_00_00_1;
    if (ins[11:7] == 5'd0) c[9] = 1'b0;
    return c;
  endfunction

  function automatic logic [124:0] exp_vec();
    return {m_instr, m_pc, m_pc4, m_valid, m_instr[19:15], m_instr[24:20],
            m_instr[11:7], ref_ctl(m_instr, m_valid)};
  endfunction

  task automatic set_bubble();
    m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
  endtask

  // One clock: advance the model with the inputs the DUT samples, then
  // move 1 ns past the edge for checking and new stimulus.
  task automatic tick();
    @(posedge clk);
    if (rst || flush_d) set_bubble();
    else if (!stall_d) begin
      m_instr = instr_f; m_pc = pc_f; m_pc4 = pcplus4_f; m_valid = valid_f;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    instr_f = ins; pc_f = pc; pcplus4_f = pc + 32'd4; valid_f = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h006283B3, 32'h100, 1'b1);
    repeat (2) tick();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_held: got %h exp %h", obs, exp_vec());
    end
    drive(NOP, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    vectors++;
    if ({instr_d, valid_d, obs_ctl} !== {32'h00000013, 1'b0, 13'b0}) begin
      miscompares++;
      $display("FAIL reset_release: got instr=%h v=%b ctl=%b", instr_d, valid_d, obs_ctl);
    end
  endtask

  task automatic test_addi();
    drive(32'h00A28293, 32'h200, 1'b1);
    tick();
    vectors++;
    if ({rd_d, regwrite_d, alusrc_d, immsrc_d, aluop_d, pc_d, pcplus4_d} !==
        {5'd5, 1'b1, 1'b1, 3'b000, 2'b10, 32'h200, 32'h204}) begin
      miscompares++;
      $display("FAIL addi: got rd=%0d rw=%b as=%b imm=%b aop=%b pc=%h", rd_d,
               regwrite_d, alusrc_d, immsrc_d, aluop_d, pc_d);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL addi_model: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h0062A223, 32'h300, 1'b1);
    tick();
    vectors++;
    if ({memwrite_d, immsrc_d, regwrite_d} !== {1'b1, 3'b001, 1'b0}) begin
      miscompares++;
      $display("FAIL sw: got mw=%b imm=%b rw=%b", memwrite_d, immsrc_d, regwrite_d);
    end
    drive(32'hFE628EE3, 32'h304, 1'b1);
    tick();
    vectors++;
    if ({branch_d, aluop_d, immsrc_d} !== {1'b1, 2'b01, 3'b010}) begin
      miscompares++;
      $display("FAIL beq: got br=%b aop=%b imm=%b", branch_d, aluop_d, immsrc_d);
    end
    drive(32'h008000EF, 32'h308, 1'b1);
    tick();
    vectors++;
    if ({jump_d, resultsrc_d, immsrc_d, rd_d, regwrite_d} !==
        {1'b1, 2'b10, 3'b011, 5'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL jal: got jp=%b res=%b imm=%b rd=%0d", jump_d, resultsrc_d, immsrc_d, rd_d);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL jal_model: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_stall_flush();
    logic [124:0] snap;
    drive(32'h0002A303, 32'h400, 1'b1);  // lw x6,0(x5)
    tick();
    snap = obs;
    vectors++;
    if ({resultsrc_d, regwrite_d, alusrc_d, rd_d} !== {2'b01, 1'b1, 1'b1, 5'd6}) begin
      miscompares++;
      $display("FAIL lw: got res=%b rw=%b rd=%0d", resultsrc_d, regwrite_d, rd_d);
    end
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 32'h500 + 32'(i * 4), 1'b1);
      tick();
      vectors++;
      if (obs !== snap || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h exp %h", i, obs, snap);
      end
    end
    flush_d = 1'b1;
    tick();
    vectors++;
    if ({instr_d, pc_d, pcplus4_d, valid_d, obs_ctl} !== {NOP, 64'h0, 1'b0, 13'b0}) begin
      miscompares++;
      $display("FAIL stall_flush: got instr=%h v=%b ctl=%b", instr_d, valid_d, obs_ctl);
    end
    stall_d = 1'b0; flush_d = 1'b0;
  endtask

  task automatic test_illegal_rd0();
    drive(32'h0000007F, 32'h600, 1'b1);
    tick();
    vectors++;
    if (obs_ctl !== 13'b000_0_0_0_0_0_00_00_1) begin
      miscompares++;
      $display("FAIL illegal: got ctl=%b exp 0000000000001", obs_ctl);
    end
    drive(32'h00128013, 32'h604, 1'b1);  // addi x0,x5,1
    tick();
    vectors++;
    if ({regwrite_d, alusrc_d, aluop_d, illegal_d} !== {1'b0, 1'b1, 2'b10, 1'b0}) begin
      miscompares++;
      $display("FAIL addi_x0: got rw=%b as=%b aop=%b ill=%b", regwrite_d, alusrc_d, aluop_d, illegal_d);
    end
  endtask

  task automatic test_async_reset();
    drive(32'h006283B3, 32'h700, 1'b1);  // add x7,x5,x6
    tick();
    vectors++;
    if ({regwrite_d, aluop_d, rd_d} !== {1'b1, 2'b10, 5'd7}) begin
      miscompares++;
      $display("FAIL rtype: got rw=%b aop=%b rd=%0d", regwrite_d, aluop_d, rd_d);
    end
    stall_d = 1'b1;
    #3 rst = 1'b1;
    #1;
    set_bubble();
    vectors++;
    if ({instr_d, pc_d, valid_d, obs_ctl} !== {NOP, 32'h0, 1'b0, 13'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got instr=%h v=%b ctl=%b", instr_d, valid_d, obs_ctl);
    end
    #2 rst = 1'b0;
    drive(32'h00A28293, 32'h800, 1'b1);
    tick();  // still stalled: bubble must persist
    vectors++;
    if (obs !== exp_vec() || valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %h exp %h", obs, exp_vec());
    end
    stall_d = 1'b0;
    tick();
    vectors++;
    if ({pc_d, valid_d, rd_d} !== {32'h800, 1'b1, 5'd5} || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL resume_after_reset: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = TBL[$urandom_range(0, 8)][19:13];
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      drive(ins, $urandom, ($urandom_range(0, 4) != 0));
      stall_d = ($urandom_range(0, 4) == 0);
      flush_d = ($urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h exp %h", n, obs, exp_vec());
      end
    end
    stall_d = 1'b0; flush_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall_flush();
    test_illegal_rd0();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
